apu_master: RTL and testbench

- CPU-side initiator for the APU request/grant/result-valid protocol that the vector accelerator responds to.
- Buffers commands from an upstream source (test sequencer or core shim) in a small FIFO and issues them to the accelerator one at a time.
- Waits for grant, then for the result-valid pulse, and returns the result and flags on a valid/ready response port.
- Sits between the instruction-issue logic and the accelerator top level.

---
 rtl/accelerator_pkg.sv | 22 ++
 rtl/apu_cmd_fifo.sv | 65 ++++++
 rtl/apu_master.sv | 216 +++++++++++++++++++++
 tb/tb_apu_master.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accelerator_pkg.sv
// Shared types and constants for the accelerator cluster: APU master FSM
// states, the buffered command record and the error/timeout encodings.
package accelerator_pkg;

    typedef enum logic [1:0] {
        APU_M_IDLE      = 2'd0,
        APU_M_REQ       = 2'd1,
        APU_M_WAIT_RESP = 2'd2
    } apu_master_state_t;

    typedef struct packed {
        logic [2:0][31:0] operands;
        logic [5:0]       op;
        logic [14:0]      flags;
    } apu_cmd_t;

    localparam int          APU_ERR_UNEXP_RVALID = 0;
    localparam int          APU_ERR_TIMEOUT      = 1;
    localparam logic [31:0] APU_TIMEOUT_RESULT   = 32'hDEAD_BEEF;
    localparam logic [4:0]  APU_TIMEOUT_FLAGS    = 5'h1F;

endpackage

// File: rtl/apu_cmd_fifo.sv
// Command FIFO for the APU master: registered head (no fall-through),
// pointers one bit wider than the index so full and empty are distinguishable.
module apu_cmd_fifo
    import accelerator_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     push,
    input  apu_cmd_t                 wr_data,
    input  logic                     pop,
    output apu_cmd_t                 rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int             IDX_W   = $clog2(DEPTH);
    localparam logic [IDX_W:0] PTR_ONE = (IDX_W + 1)'(1'b1);

    apu_cmd_t       mem_r [DEPTH];
    logic [IDX_W:0] wr_ptr_r;
    logic [IDX_W:0] rd_ptr_r;
    logic           do_push_s;
    logic           do_pop_s;

    // Status flags, qualified handshakes and head-of-queue read.
    always_comb begin
        empty     = (wr_ptr_r == rd_ptr_r);
        full      = (wr_ptr_r[IDX_W] != rd_ptr_r[IDX_W]) &&
                    (wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]);
        count     = wr_ptr_r - rd_ptr_r;
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
        rd_data   = mem_r[rd_ptr_r[IDX_W-1:0]];
    end

    // Read/write pointer registers; a simultaneous push and pop keeps the count.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Storage array, cleared on reset so the head never presents X.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r[IDX_W-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/apu_master.sv
// CPU-side APU initiator: queues commands, issues one request at a time,
// waits for grant and result strobe, and returns results on a valid/ready port.
module apu_master
    import accelerator_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0][31:0] cmd_operands,
    input  logic [5:0]       cmd_op,
    input  logic [14:0]      cmd_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [4:0]       rsp_flags,
    output logic             apu_req,
    output logic [2:0][31:0] apu_operands_o,
    output logic [5:0]       apu_op_o,
    output logic [14:0]      apu_flags_o,
    input  logic             apu_gnt,
    input  logic             apu_rvalid,
    input  logic [31:0]      apu_result,
    input  logic [4:0]       apu_flags_i,
    output logic             busy,
    output logic [1:0]       err,
    input  logic             err_clear
);

    localparam int               CNT_W         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1'b1);
    localparam logic [31:0]      TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

    apu_master_state_t          state_r;
    apu_master_state_t          state_next_s;
    apu_cmd_t                   fifo_wr_s;
    apu_cmd_t                   fifo_head_s;
    apu_cmd_t                   apu_cmd_r;
    logic                       fifo_full_s;
    logic                       fifo_empty_s;
    logic [$clog2(FIFO_DEPTH):0] fifo_count_s;
    logic                       push_s;
    logic                       issue_s;
    logic                       grant_s;
    logic                       capture_s;
    logic                       timeout_s;
    logic                       timeout_hit_s;
    logic                       unexp_rvalid_s;
    logic [1:0]                 err_set_s;
    logic [CNT_W-1:0]           tmo_cnt_r;
    logic                       apu_req_r;
    logic                       rsp_valid_r;
    logic [31:0]                rsp_result_r;
    logic [4:0]                 rsp_flags_r;
    logic [1:0]                 err_r;

    assign fifo_wr_s.operands = cmd_operands;
    assign fifo_wr_s.op       = cmd_op;
    assign fifo_wr_s.flags    = cmd_flags;
    assign push_s             = cmd_valid && !fifo_full_s;

    apu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (push_s),
        .wr_data (fifo_wr_s),
        .pop     (issue_s),
        .rd_data (fifo_head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // Timeout fires on the last permitted WAIT_RESP cycle; a zero limit disables it.
    always_comb begin
        timeout_hit_s = (TIMEOUT_LIMIT != 32'd0) &&
                        ((32'(tmo_cnt_r) + 32'd1) == TIMEOUT_LIMIT);
    end

    // Next-state logic and the per-cycle control strobes.
    always_comb begin
        state_next_s   = state_r;
        issue_s        = 1'b0;
        grant_s        = 1'b0;
        capture_s      = 1'b0;
        timeout_s      = 1'b0;
        unexp_rvalid_s = 1'b0;
        case (state_r)
            APU_M_IDLE: begin
                unexp_rvalid_s = apu_rvalid;
                // Issue only when the response slot is free, so a result always has a home.
                if (!fifo_empty_s && (!rsp_valid_r || rsp_ready)) begin
                    issue_s      = 1'b1;
                    state_next_s = APU_M_REQ;
                end else begin
                    state_next_s = APU_M_IDLE;
                end
            end
            APU_M_REQ: begin
                if (apu_gnt) begin
                    grant_s = 1'b1;
                    if (apu_rvalid) begin
                        capture_s    = 1'b1;
                        state_next_s = APU_M_IDLE;
                    end else begin
                        state_next_s = APU_M_WAIT_RESP;
                    end
                end else begin
                    unexp_rvalid_s = apu_rvalid;
                    state_next_s   = APU_M_REQ;
                end
            end
            APU_M_WAIT_RESP: begin
                if (apu_rvalid) begin
                    capture_s    = 1'b1;
                    state_next_s = APU_M_IDLE;
                end else if (timeout_hit_s) begin
                    timeout_s    = 1'b1;
                    state_next_s = APU_M_IDLE;
                end else begin
                    state_next_s = APU_M_WAIT_RESP;
                end
            end
            default: begin
                state_next_s = APU_M_IDLE;
            end
        endcase
    end

    // Map error events onto their sticky bit positions.
    always_comb begin
        err_set_s                       = 2'b00;
        err_set_s[APU_ERR_UNEXP_RVALID] = unexp_rvalid_s;
        err_set_s[APU_ERR_TIMEOUT]      = timeout_s;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r <= APU_M_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Request side: load the head entry on issue, hold it stable until grant.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            apu_req_r <= 1'b0;
            apu_cmd_r <= '0;
        end else if (issue_s) begin
            apu_req_r <= 1'b1;
            apu_cmd_r <= fifo_head_s;
        end else if (grant_s) begin
            apu_req_r <= 1'b0;
        end
    end

    // WAIT_RESP cycle counter, cleared whenever the state is left.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            tmo_cnt_r <= '0;
        end else if ((state_r == APU_M_WAIT_RESP) && (state_next_s == APU_M_WAIT_RESP)) begin
            tmo_cnt_r <= tmo_cnt_r + CNT_ONE;
        end else begin
            tmo_cnt_r <= '0;
        end
    end

    // Response slot: a capture or timeout fills it, the consumer handshake empties it.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rsp_valid_r  <= 1'b0;
            rsp_result_r <= 32'd0;
            rsp_flags_r  <= 5'd0;
        end else if (capture_s) begin
            rsp_valid_r  <= 1'b1;
            rsp_result_r <= apu_result;
            rsp_flags_r  <= apu_flags_i;
        end else if (timeout_s) begin
            rsp_valid_r  <= 1'b1;
            rsp_result_r <= APU_TIMEOUT_RESULT;
            rsp_flags_r  <= APU_TIMEOUT_FLAGS;
        end else if (rsp_valid_r && rsp_ready) begin
            rsp_valid_r  <= 1'b0;
        end
    end

    // Sticky error bits; a clear wins over a same-cycle set.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            err_r <= 2'b00;
        end else if (err_clear) begin
            err_r <= 2'b00;
        end else begin
            err_r <= err_r | err_set_s;
        end
    end

    assign cmd_ready      = !fifo_full_s;
    assign apu_req        = apu_req_r;
    assign apu_operands_o = apu_cmd_r.operands;
    assign apu_op_o       = apu_cmd_r.op;
    assign apu_flags_o    = apu_cmd_r.flags;
    assign rsp_valid      = rsp_valid_r;
    assign rsp_result     = rsp_result_r;
    assign rsp_flags      = rsp_flags_r;
    assign err            = err_r;
    assign busy           = (fifo_count_s != '0) || (state_r != APU_M_IDLE) || rsp_valid_r;

endmodule

// File: tb/tb_apu_master.sv
// Self-checking bench for apu_master: table-driven single transactions, hand
// sequences for back-pressure/timeout/reset, and a randomized in-order scoreboard.
module tb_apu_master;

    localparam int TMO = 8;

    logic             clk = 1'b0;
    logic             n_reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0][31:0] cmd_operands;
    logic [5:0]       cmd_op;
    logic [14:0]      cmd_flags;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [4:0]       rsp_flags;
    logic             apu_req;
    logic [2:0][31:0] apu_operands_o;
    logic [5:0]       apu_op_o;
    logic [14:0]      apu_flags_o;
    logic             apu_gnt;
    logic             apu_rvalid;
    logic [31:0]      apu_result;
    logic [4:0]       apu_flags_i;
    logic             busy;
    logic [1:0]       err;
    logic             err_clear;

    always #5 clk = ~clk;

    apu_master #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .n_reset(n_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_operands(cmd_operands),
        .cmd_op(cmd_op), .cmd_flags(cmd_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .apu_req(apu_req), .apu_operands_o(apu_operands_o), .apu_op_o(apu_op_o), .apu_flags_o(apu_flags_o),
        .apu_gnt(apu_gnt), .apu_rvalid(apu_rvalid), .apu_result(apu_result), .apu_flags_i(apu_flags_i),
        .busy(busy), .err(err), .err_clear(err_clear)
    );

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  flags;
    } rsp_t;

    typedef struct {
        logic [31:0] op0, op1, op2;
        logic [5:0]  op;
        logic [14:0] flags;
        int          gnt_delay;
        int          lat;
        logic [31:0] acc_res;
        logic [4:0]  acc_flg;
        int          exp_req_cycles;
    } row_t;

    rsp_t exp_q[$];
    row_t rows[4];
    int   n_pass = 0, n_total = 0, cyc = 0, n_accepted = 0;

    // Accelerator model state
    int          acc_gnt_delay = 0, acc_lat = 1, req_wait = 0, rv_cd = -1;
    bit          acc_stall = 1'b0, acc_fixed = 1'b0;
    logic [31:0] acc_res_fixed = 32'd0;
    logic [4:0]  acc_flg_fixed = 5'd0;
    rsp_t        pend;
    int          last_rv_step = -100, last_gnt_step = -100;

    function automatic rsp_t acc_fn(input logic [2:0][31:0] ops, input logic [5:0] op, input logic [14:0] fl);
        rsp_t r;
        r.result = ops[0] ^ (ops[1] + ops[2]) ^ {26'd0, op};
        r.flags  = fl[4:0] ^ op[4:0];
        return r;
    endfunction

    function automatic rsp_t expect_for();
        rsp_t r;
        if (acc_lat < 0) begin
            r.result = 32'hDEAD_BEEF;
            r.flags  = 5'h1F;
        end else if (acc_fixed) begin
            r.result = acc_res_fixed;
            r.flags  = acc_flg_fixed;
        end else begin
            r = acc_fn(cmd_operands, cmd_op, cmd_flags);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic acc_update();
        rsp_t r;
        apu_gnt = 1'b0; apu_rvalid = 1'b0; apu_result = 32'd0; apu_flags_i = 5'd0;
        if (rv_cd > 0) begin
            rv_cd--;
            if (rv_cd == 0) begin
                apu_rvalid = 1'b1; apu_result = pend.result; apu_flags_i = pend.flags;
                last_rv_step = cyc; rv_cd = -1;
            end
        end
        if (apu_req && !acc_stall) begin
            if (req_wait >= acc_gnt_delay) begin
                apu_gnt = 1'b1; last_gnt_step = cyc; req_wait = 0;
                if (acc_fixed) begin
                    r.result = acc_res_fixed; r.flags = acc_flg_fixed;
                end else begin
                    r = acc_fn(apu_operands_o, apu_op_o, apu_flags_o);
                end
                if (acc_lat == 0) begin
                    apu_rvalid = 1'b1; apu_result = r.result; apu_flags_i = r.flags; last_rv_step = cyc;
                end else if (acc_lat > 0) begin
                    rv_cd = acc_lat; pend = r;
                end
            end else begin
                req_wait++;
            end
        end else begin
            req_wait = 0;
        end
    endtask

    // Account for handshakes that complete at the coming edge, then advance one cycle.
    task automatic step();
        rsp_t e;
        if (cmd_valid && cmd_ready) begin
            exp_q.push_back(expect_for());
            n_accepted++;
        end
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL rsp_unexpected: got response 0x%0h, required none", rsp_result);
            end else begin
                e = exp_q.pop_front();
                check("rsp_result", {32'd0, rsp_result}, {32'd0, e.result});
                check("rsp_flags", {59'd0, rsp_flags}, {59'd0, e.flags});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        acc_update();
    endtask

    task automatic rand_cmd();
        cmd_operands = {$urandom(), $urandom(), $urandom()};
        cmd_op       = 6'($urandom());
        cmd_flags    = 15'($urandom());
    endtask

    task automatic check_reset_outputs();
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_data", {27'd0, rsp_flags, rsp_result}, 64'd0);
        check("rst_apu_req", {63'd0, apu_req}, 64'd0);
        check("rst_apu_bus", {63'd0, |{apu_operands_o, apu_op_o, apu_flags_o}}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_err", {62'd0, err}, 64'd0);
    endtask

    task automatic bench_reset_state();
        exp_q.delete();
        rv_cd = -1; req_wait = 0;
        apu_gnt = 1'b0; apu_rvalid = 1'b0; apu_result = 32'd0; apu_flags_i = 5'd0;
        cmd_valid = 1'b0;
    endtask

    task automatic run_row(input row_t r, input int idx);
        int req_n, bad, rsp_step;
        acc_fixed = 1'b1; acc_res_fixed = r.acc_res; acc_flg_fixed = r.acc_flg;
        acc_gnt_delay = r.gnt_delay; acc_lat = r.lat; rsp_ready = 1'b1;
        last_rv_step = -100;
        cmd_operands = {r.op2, r.op1, r.op0}; cmd_op = r.op; cmd_flags = r.flags; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        req_n = 0; bad = 0; rsp_step = -1;
        for (int k = 0; k < 40; k++) begin
            if (apu_req) begin
                req_n++;
                if ({apu_operands_o, apu_op_o, apu_flags_o} !== {r.op2, r.op1, r.op0, r.op, r.flags}) bad++;
            end
            if (rsp_valid) begin
                rsp_step = cyc;
                break;
            end
            step();
        end
        check($sformatf("row%0d_req_cycles", idx), 64'(req_n), 64'(r.exp_req_cycles));
        check($sformatf("row%0d_apu_bus_stable", idx), 64'(bad), 64'd0);
        check($sformatf("row%0d_rsp_latency", idx), 64'(rsp_step), 64'(last_rv_step + 1));
        check($sformatf("row%0d_err", idx), {62'd0, err}, 64'd0);
        step();
        check($sformatf("row%0d_rsp_drained", idx), {63'd0, rsp_valid}, 64'd0);
        check($sformatf("row%0d_idle", idx), {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int base, k, bad, held_bad, steps_used, rsp_step;
        logic [31:0] r1;
        logic [4:0]  f1;

        rows[0] = '{32'd10, 32'd3, 32'd0, 6'h01, 15'h0000, 0, 2, 32'd4, 5'h00, 1};
        rows[1] = '{32'hA5A5_0001, 32'h0000_00FF, 32'h8000_0000, 6'h2A, 15'h7FFF, 3, 1, 32'h1234_5678, 5'h15, 4};
        rows[2] = '{32'hFFFF_FFFF, 32'd0, 32'd7, 6'h3F, 15'h1234, 1, 0, 32'hFFFF_FFFF, 5'h1F, 2};
        rows[3] = '{32'd1, 32'd2, 32'd3, 6'h00, 15'h4000, 0, 0, 32'd0, 5'h01, 1};

        n_reset = 1'b0; cmd_valid = 1'b0; cmd_operands = '0; cmd_op = 6'd0; cmd_flags = 15'd0;
        rsp_ready = 1'b0; apu_gnt = 1'b0; apu_rvalid = 1'b0; apu_result = 32'd0; apu_flags_i = 5'd0;
        err_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        n_reset = 1'b1;
        step();

        // Single transactions from the table
        for (int i = 0; i < 4; i++) run_row(rows[i], i);

        // Five back-to-back commands against a stalled accelerator
        acc_fixed = 1'b0; acc_stall = 1'b1; acc_lat = 2; acc_gnt_delay = 0; rsp_ready = 1'b1;
        base = n_accepted; steps_used = 0;
        while ((n_accepted - base) < 5 && steps_used < 20) begin
            rand_cmd(); cmd_valid = 1'b1;
            step();
            steps_used++;
        end
        cmd_valid = 1'b0;
        check("fifo_accept_steps", 64'(steps_used), 64'd5);
        check("fifo_full_ready", {63'd0, cmd_ready}, 64'd0);
        check("fifo_one_in_req", {63'd0, apu_req}, 64'd1);
        check("fifo_busy", {63'd0, busy}, 64'd1);
        acc_stall = 1'b0;
        for (k = 0; k < 200 && exp_q.size() != 0; k++) step();
        check("fifo_drain_left", 64'(exp_q.size()), 64'd0);

        // Response back-pressure blocks the next issue
        acc_lat = 1; rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_cmd(); cmd_valid = 1'b1;
            step();
        end
        cmd_valid = 1'b0;
        for (k = 0; k < 30 && !rsp_valid; k++) step();
        r1 = rsp_result; f1 = rsp_flags;
        check("bp_first_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        bad = 0; held_bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (apu_req) bad++;
            if (!rsp_valid || rsp_result !== r1 || rsp_flags !== f1) held_bad++;
        end
        check("bp_no_second_req", 64'(bad), 64'd0);
        check("bp_rsp_held", 64'(held_bad), 64'd0);
        rsp_ready = 1'b1;
        for (k = 0; k < 40 && (exp_q.size() != 0 || busy); k++) step();
        check("bp_drain_left", 64'(exp_q.size()), 64'd0);

        // Timeout: the accelerator grants but never returns a result
        acc_lat = -1; acc_gnt_delay = 0; rsp_ready = 1'b0; last_gnt_step = -100;
        rand_cmd(); cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        rsp_step = -1;
        for (k = 0; k < 40; k++) begin
            if (rsp_valid) begin
                rsp_step = cyc;
                break;
            end
            step();
        end
        check("tmo_latency", 64'(rsp_step - last_gnt_step), 64'(TMO + 1));
        check("tmo_err", {62'd0, err}, 64'd2);
        check("tmo_result", {32'd0, rsp_result}, 64'hDEAD_BEEF);
        check("tmo_flags", {59'd0, rsp_flags}, 64'h1F);
        check("tmo_no_req", {63'd0, apu_req}, 64'd0);
        rsp_ready = 1'b1;
        step();
        check("tmo_idle", {63'd0, busy}, 64'd0);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check("tmo_err_cleared", {62'd0, err}, 64'd0);
        apu_rvalid = 1'b1; apu_result = 32'h0BAD_0BAD; err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check("err_clear_priority", {62'd0, err}, 64'd0);

        // Randomized traffic against the in-order scoreboard
        acc_fixed = 1'b0; base = n_accepted;
        for (k = 0; k < 3000; k++) begin
            acc_gnt_delay = int'($urandom_range(0, 3));
            acc_lat       = int'($urandom_range(0, 6));
            rsp_ready     = ($urandom_range(0, 3) != 0);
            if ((n_accepted - base) >= 40 && exp_q.size() == 0 && !busy) break;
            if ((n_accepted - base) < 40 && $urandom_range(0, 1) == 1) begin
                rand_cmd(); cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            step();
        end
        cmd_valid = 1'b0;
        check("rand_accepted", 64'(n_accepted - base), 64'd40);
        check("rand_drain_left", 64'(exp_q.size()), 64'd0);
        check("rand_err", {62'd0, err}, 64'd0);
        check("rand_idle", {63'd0, busy}, 64'd0);

        // Unexpected rvalid in IDLE, then reset in the middle of WAIT_RESP
        apu_rvalid = 1'b1; apu_result = 32'hCAFE_F00D; apu_flags_i = 5'h0A; rsp_ready = 1'b1;
        step();
        check("unexp_err0", {62'd0, err}, 64'd1);
        check("unexp_no_rsp", {63'd0, rsp_valid}, 64'd0);
        acc_lat = -1; acc_gnt_delay = 0; last_gnt_step = -100;
        rand_cmd(); cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (k = 0; k < 20 && last_gnt_step < 0; k++) step();
        step();
        step();
        check("pre_reset_err", {62'd0, err}, 64'd1);
        check("pre_reset_busy", {63'd0, busy}, 64'd1);
        #2;
        n_reset = 1'b0;
        #1;
        check_reset_outputs();
        bench_reset_state();
        @(negedge clk);
        n_reset = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("post_reset_no_req", {63'd0, apu_req}, 64'd0);
        check("post_reset_busy", {63'd0, busy}, 64'd0);
        check("post_reset_rsp", {63'd0, rsp_valid}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
